// File: rtl/i2c_wbs_req_master_8_pkg.sv
// ----------------------------------------------------------------------------
// i2c_wbs_req_master_8_pkg
// Shared definitions for the library's Wishbone request masters:
//   - wb_state_e         : IDLE / BUS / RESP state encoding
//   - WB_TIMEOUT_DEFAULT : default ack wait limit in clock cycles
// ----------------------------------------------------------------------------
package i2c_wbs_req_master_8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    localparam int WB_TIMEOUT_DEFAULT = 256;

endpackage : i2c_wbs_req_master_8_pkg

// File: rtl/i2c_wbs_req_master_8.sv
// ----------------------------------------------------------------------------
// i2c_wbs_req_master_8
// Converts a valid/ready request stream into single Wishbone classic cycles
// towards the 8-bit I2C master register block and returns one response per
// request (read data, or an error when the slave fails to ack in time).
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   s_req_addr/data/we        request: register address, write data, write flag
//   s_req_valid/ready         request handshake
//   m_rsp_data/err            response: read data (0 for writes/errors), timeout
//   m_rsp_valid/ready         response handshake
//   wbm_adr_o/dat_o/we_o      Wishbone address, write data, write enable
//   wbm_stb_o/cyc_o           Wishbone strobe and cycle (always driven together)
//   wbm_dat_i/ack_i           Wishbone read data and acknowledge
//   busy                      high whenever a transaction is in flight
// ----------------------------------------------------------------------------
module i2c_wbs_req_master_8
    import i2c_wbs_req_master_8_pkg::*;
#(
    parameter int ADDR_WIDTH    = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int TIMEOUT       = WB_TIMEOUT_DEFAULT,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_req_addr,
    input  logic [DATA_WIDTH-1:0] s_req_data,
    input  logic                  s_req_we,
    input  logic                  s_req_valid,
    output logic                  s_req_ready,
    output logic [DATA_WIDTH-1:0] m_rsp_data,
    output logic                  m_rsp_err,
    output logic                  m_rsp_valid,
    input  logic                  m_rsp_ready,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [DATA_WIDTH-1:0] wbm_dat_o,
    input  logic [DATA_WIDTH-1:0] wbm_dat_i,
    output logic                  wbm_we_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_cyc_o,
    input  logic                  wbm_ack_i,
    output logic                  busy
);

    // A zero TIMEOUT means wait for ack forever.
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);
    // Timer value seen on the last permitted bus cycle.
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
        TIMEOUT_EN ? TIMEOUT_WIDTH'(TIMEOUT - 1) : {TIMEOUT_WIDTH{1'b0}};

    wb_state_e               state_r,     state_s;
    logic [TIMEOUT_WIDTH-1:0] timer_r,    timer_s;
    logic [ADDR_WIDTH-1:0]   adr_r,       adr_s;
    logic [DATA_WIDTH-1:0]   dat_r,       dat_s;
    logic                    we_r,        we_s;
    logic                    cyc_r,       cyc_s;
    logic [DATA_WIDTH-1:0]   rsp_data_r,  rsp_data_s;
    logic                    rsp_err_r,   rsp_err_s;
    logic                    rsp_valid_r, rsp_valid_s;
    logic                    timeout_hit_s;

    // Last permitted cycle of the ack wait has been reached.
    always_comb begin
        timeout_hit_s = 1'b0;
        if (TIMEOUT_EN && (timer_r == TIMEOUT_LAST)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Next-state and next-register logic for the request/bus/response sequence.
    always_comb begin
        state_s     = state_r;
        timer_s     = timer_r;
        adr_s       = adr_r;
        dat_s       = dat_r;
        we_s        = we_r;
        cyc_s       = cyc_r;
        rsp_data_s  = rsp_data_r;
        rsp_err_s   = rsp_err_r;
        rsp_valid_s = rsp_valid_r;
        case (state_r)
            ST_IDLE: begin
                // s_req_ready is high throughout IDLE, so valid alone accepts.
                if (s_req_valid) begin
                    adr_s   = s_req_addr;
                    dat_s   = s_req_data;
                    we_s    = s_req_we;
                    timer_s = {TIMEOUT_WIDTH{1'b0}};
                    cyc_s   = 1'b1;
                    state_s = ST_BUS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                timer_s = timer_r + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
                // Ack is checked first so a late ack on the final cycle still wins.
                if (wbm_ack_i) begin
                    rsp_data_s  = we_r ? {DATA_WIDTH{1'b0}} : wbm_dat_i;
                    rsp_err_s   = 1'b0;
                    rsp_valid_s = 1'b1;
                    cyc_s       = 1'b0;
                    state_s     = ST_RESP;
                end else if (timeout_hit_s) begin
                    rsp_data_s  = {DATA_WIDTH{1'b0}};
                    rsp_err_s   = 1'b1;
                    rsp_valid_s = 1'b1;
                    cyc_s       = 1'b0;
                    state_s     = ST_RESP;
                end else begin
                    state_s = ST_BUS;
                end
            end
            ST_RESP: begin
                if (m_rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                cyc_s       = 1'b0;
                rsp_valid_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any bus cycle and response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            timer_r     <= {TIMEOUT_WIDTH{1'b0}};
            adr_r       <= {ADDR_WIDTH{1'b0}};
            dat_r       <= {DATA_WIDTH{1'b0}};
            we_r        <= 1'b0;
            cyc_r       <= 1'b0;
            rsp_data_r  <= {DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            timer_r     <= timer_s;
            adr_r       <= adr_s;
            dat_r       <= dat_s;
            we_r        <= we_s;
            cyc_r       <= cyc_s;
            rsp_data_r  <= rsp_data_s;
            rsp_err_r   <= rsp_err_s;
            rsp_valid_r <= rsp_valid_s;
        end
    end

    // Gating with rst keeps ready low during reset even though state reads IDLE.
    assign s_req_ready = (state_r == ST_IDLE) && !rst;
    assign busy        = (state_r != ST_IDLE);
    assign wbm_adr_o   = adr_r;
    assign wbm_dat_o   = dat_r;
    assign wbm_we_o    = we_r;
    assign wbm_cyc_o   = cyc_r;
    assign wbm_stb_o   = cyc_r;
    assign m_rsp_data  = rsp_data_r;
    assign m_rsp_err   = rsp_err_r;
    assign m_rsp_valid = rsp_valid_r;

endmodule : i2c_wbs_req_master_8

// File: tb/tb_i2c_wbs_req_master_8.sv
module tb_i2c_wbs_req_master_8;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] s_req_addr;
    logic [7:0] s_req_data;
    logic       s_req_we;
    logic       s_req_valid;
    logic       s_req_ready;
    logic [7:0] m_rsp_data;
    logic       m_rsp_err;
    logic       m_rsp_valid;
    logic       m_rsp_ready;
    logic [2:0] wbm_adr_o;
    logic [7:0] wbm_dat_o;
    logic [7:0] wbm_dat_i;
    logic       wbm_we_o;
    logic       wbm_stb_o;
    logic       wbm_cyc_o;
    logic       wbm_ack_i;
    logic       busy;

    i2c_wbs_req_master_8 #(
        .ADDR_WIDTH(3), .DATA_WIDTH(8), .TIMEOUT(TO), .TIMEOUT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .s_req_addr(s_req_addr), .s_req_data(s_req_data), .s_req_we(s_req_we),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .m_rsp_data(m_rsp_data), .m_rsp_err(m_rsp_err),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_ack_i(wbm_ack_i), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Slave plan: plan_k > 0 fixes which cyc-high cycle carries ack (and its data);
    // plan_k == 0 picks a random ack cycle, possibly past the timeout.
    int         plan_k = 0;
    logic [7:0] plan_rd = 8'h00;
    int         cur_k = 1;
    int         scnt = 0;

    // Wishbone slave: ack in the cur_k-th cycle of cyc; stray acks while idle.
    initial begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (wbm_cyc_o) begin
                if (scnt == 0) cur_k = (plan_k > 0) ? plan_k : int'($urandom_range(TO + 3, 1));
                scnt++;
                wbm_ack_i = (scnt == cur_k);
                wbm_dat_i = (scnt == cur_k && plan_k > 0) ? plan_rd : 8'($urandom);
            end else begin
                scnt = 0;
                wbm_ack_i = ($urandom_range(3, 0) == 0);
                wbm_dat_i = 8'($urandom);
            end
        end
    end

    // Behavioural model: an accepted request holds cyc for min(k, TO) cycles,
    // then the response is err = (k > TO), data = read && !err ? ack data : 0.
    bit         in_bus = 0, in_resp = 0;
    int         cnt = 0, cyc_no = 0, last_acc = 0, last_gap = 0;
    int         last_bus_len = 0, rsp_count = 0;
    logic [2:0] exp_adr;
    logic [7:0] exp_dat, exp_data;
    logic       exp_we, exp_err;
    logic [7:0] last_rsp_data;
    logic       last_rsp_err;

    initial begin
        forever begin
            @(negedge clk);
            cyc_no++;
            if (rst) begin
                chk("rst_cyc", wbm_cyc_o, 0);
                chk("rst_stb", wbm_stb_o, 0);
                chk("rst_busy", busy, 0);
                chk("rst_ready", s_req_ready, 0);
                chk("rst_rvalid", m_rsp_valid, 0);
                chk("rst_rerr", m_rsp_err, 0);
                chk("rst_rdata", m_rsp_data, 0);
                chk("rst_adr", wbm_adr_o, 0);
                chk("rst_dat", wbm_dat_o, 0);
                chk("rst_we", wbm_we_o, 0);
                in_bus = 0;
                in_resp = 0;
            end else if (in_bus) begin
                cnt++;
                chk("bus_cyc", wbm_cyc_o, 1);
                chk("bus_stb", wbm_stb_o, 1);
                chk("bus_adr", wbm_adr_o, exp_adr);
                chk("bus_dat", wbm_dat_o, exp_dat);
                chk("bus_we", wbm_we_o, exp_we);
                chk("bus_busy", busy, 1);
                chk("bus_ready", s_req_ready, 0);
                chk("bus_rvalid", m_rsp_valid, 0);
                if (cnt == ((cur_k <= TO) ? cur_k : TO)) begin
                    exp_err  = (cur_k > TO);
                    exp_data = (exp_err || exp_we) ? 8'h00 : wbm_dat_i;
                    last_bus_len = cnt;
                    in_bus  = 0;
                    in_resp = 1;
                end
            end else if (in_resp) begin
                chk("rsp_valid", m_rsp_valid, 1);
                chk("rsp_data", m_rsp_data, exp_data);
                chk("rsp_err", m_rsp_err, exp_err);
                chk("rsp_cyc", wbm_cyc_o, 0);
                chk("rsp_stb", wbm_stb_o, 0);
                chk("rsp_busy", busy, 1);
                chk("rsp_ready", s_req_ready, 0);
                if (m_rsp_ready) begin
                    last_rsp_data = m_rsp_data;
                    last_rsp_err  = m_rsp_err;
                    rsp_count++;
                    in_resp = 0;
                end
            end else begin
                chk("idle_cyc", wbm_cyc_o, 0);
                chk("idle_stb", wbm_stb_o, 0);
                chk("idle_busy", busy, 0);
                chk("idle_ready", s_req_ready, 1);
                chk("idle_rvalid", m_rsp_valid, 0);
                if (s_req_valid) begin
                    exp_adr  = s_req_addr;
                    exp_dat  = s_req_data;
                    exp_we   = s_req_we;
                    cnt      = 0;
                    last_gap = cyc_no - last_acc;
                    last_acc = cyc_no;
                    in_bus   = 1;
                end
            end
        end
    end

    task automatic wait_accept();
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (s_req_ready) ok = 1;
        end
        chk("accept_timeout", ok, 1);
        @(posedge clk); #1;
        s_req_valid = 1'b0;
        s_req_addr  = 3'($urandom);
        s_req_data  = 8'($urandom);
        s_req_we    = 1'($urandom);
    endtask

    task automatic do_req(input logic [2:0] a, input logic [7:0] d, input logic w,
                          input int k, input logic [7:0] rd, input int bp);
        bit ok = 0;
        plan_k  = k;
        plan_rd = rd;
        s_req_addr  = a;
        s_req_data  = d;
        s_req_we    = w;
        s_req_valid = 1'b1;
        m_rsp_ready = (bp == 0);
        wait_accept();
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (m_rsp_valid) ok = 1;
        end
        chk("rsp_timeout", ok, 1);
        if (bp > 0) begin
            repeat (bp) @(posedge clk);
            #1 m_rsp_ready = 1'b1;
            @(posedge clk); #1;
            m_rsp_ready = 1'b0;
        end else begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n0;
        rst = 1'b1;
        s_req_addr = 3'd0; s_req_data = 8'h00; s_req_we = 1'b0;
        s_req_valid = 1'b0; m_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Write, ack in first strobe cycle.
        do_req(3'd3, 8'h5A, 1'b1, 1, 8'hEE, 0);
        chk("wr_len", last_bus_len, 1);
        chk("wr_data", last_rsp_data, 8'h00);
        chk("wr_err", last_rsp_err, 0);

        // Read, ack in second strobe cycle.
        do_req(3'd4, 8'h11, 1'b0, 2, 8'hC3, 0);
        chk("rd_len", last_bus_len, 2);
        chk("rd_data", last_rsp_data, 8'hC3);
        chk("rd_err", last_rsp_err, 0);

        // No ack: timeout after exactly TO strobe cycles.
        do_req(3'd1, 8'h22, 1'b0, 30, 8'h99, 0);
        chk("to_len", last_bus_len, 8);
        chk("to_data", last_rsp_data, 8'h00);
        chk("to_err", last_rsp_err, 1);

        // Response backpressure for 5 cycles.
        do_req(3'd6, 8'h33, 1'b0, 1, 8'h77, 5);
        chk("bp_data", last_rsp_data, 8'h77);
        chk("bp_err", last_rsp_err, 0);

        // Ack on the final timeout cycle wins.
        do_req(3'd7, 8'h44, 1'b0, 8, 8'hA5, 0);
        chk("last_len", last_bus_len, 8);
        chk("last_data", last_rsp_data, 8'hA5);
        chk("last_err", last_rsp_err, 0);

        // Back-to-back with 1-cycle ack and ready held high.
        plan_k = 1; plan_rd = 8'h5C;
        m_rsp_ready = 1'b1;
        s_req_valid = 1'b1; s_req_addr = 3'd2; s_req_data = 8'h66; s_req_we = 1'b1;
        repeat (12) @(posedge clk);
        #1 s_req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("b2b_gap", last_gap, 3);

        // Reset two cycles into a read.
        plan_k = 50;
        n0 = rsp_count;
        m_rsp_ready = 1'b0;
        s_req_valid = 1'b1; s_req_addr = 3'd5; s_req_we = 1'b0;
        wait_accept();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_cyc", wbm_cyc_o, 0);
        chk("arst_stb", wbm_stb_o, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_rsp_ready = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("arst_no_rsp", rsp_count, n0);
        do_req(3'd0, 8'hF0, 1'b0, 3, 8'h3C, 0);
        chk("post_rst_data", last_rsp_data, 8'h3C);
        chk("post_rst_cnt", rsp_count, n0 + 1);

        // Randomised traffic checked every cycle by the model.
        plan_k = 0;
        repeat (600) begin
            @(posedge clk); #1;
            s_req_valid = 1'($urandom);
            s_req_addr  = 3'($urandom);
            s_req_data  = 8'($urandom);
            s_req_we    = 1'($urandom);
            m_rsp_ready = ($urandom_range(3, 0) != 0);
        end
        s_req_valid = 1'b0;
        m_rsp_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("drain_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_i2c_wbs_req_master_8

// File: doc/i2c_wbs_req_master_8.md
Name: i2c_wbs_req_master_8

Overview:
- Upstream driver for the 8-bit Wishbone I2C master register block.
- Converts a simple valid/ready request stream (address, data, write-enable) into single Wishbone classic cycles.
- Returns one response per request: read data or error, on a valid/ready stream.
- Adds a bounded-wait timeout so a missing ack cannot hang the control path (host bridge, init sequencer).

Parameters:
ADDR_WIDTH, 3, Wishbone address width; matches the 8-register map of the I2C master.
DATA_WIDTH, 8, Wishbone data width; fixed at 8 for this block.
TIMEOUT, 256, cycles to wait for ack before aborting; 0 disables the timeout (wait forever).
TIMEOUT_WIDTH, 16, width of the timeout counter; TIMEOUT must be < 2^TIMEOUT_WIDTH.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
s_req_addr  in  ADDR_WIDTH  request register address.
s_req_data  in  DATA_WIDTH  write data; ignored for reads.
s_req_we  in  1  1 = write, 0 = read.
s_req_valid  in  1  request valid.
s_req_ready  out  1  request accepted when valid & ready.
m_rsp_data  out  DATA_WIDTH  read data; 0 for writes and on error.
m_rsp_err  out  1  1 = timeout abort.
m_rsp_valid  out  1  response valid.
m_rsp_ready  in  1  response consumed when valid & ready.
wbm_adr_o  out  ADDR_WIDTH  Wishbone address.
wbm_dat_o  out  DATA_WIDTH  Wishbone write data.
wbm_dat_i  in  DATA_WIDTH  Wishbone read data.
wbm_we_o  out  1  Wishbone write enable.
wbm_stb_o  out  1  Wishbone strobe.
wbm_cyc_o  out  1  Wishbone cycle.
wbm_ack_i  in  1  Wishbone acknowledge.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - wbm_cyc_o, wbm_stb_o, wbm_we_o, m_rsp_valid, m_rsp_err and busy go to 0.
  - wbm_adr_o, wbm_dat_o and m_rsp_data go to 0.
  - Timer goes to 0.
  - s_req_ready is 0 while rst is high; it is 1 in IDLE otherwise.
- All outputs are registered or decoded from the state register only.
- IDLE:
  - s_req_ready = 1.
  - On s_req_valid & s_req_ready at edge N: latch addr, data and we into the Wishbone output registers; clear the timer; go to BUS.
  - wbm_cyc_o and wbm_stb_o are high from cycle N+1.
- BUS:
  - cyc, stb, adr, dat and we are held stable; s_req_ready = 0.
  - Timer increments each cycle.
  - wbm_ack_i high at edge M: capture wbm_dat_i into m_rsp_data if read (else 0); m_rsp_err = 0; go to RESP.
  - Otherwise, if TIMEOUT != 0 and timer == TIMEOUT-1 at edge M: m_rsp_data = 0; m_rsp_err = 1; go to RESP.
  - In both cases cyc and stb drop and m_rsp_valid rises at M+1.
  - Ack and timeout in the same cycle: ack wins, err = 0.
- RESP:
  - m_rsp_valid = 1; data and err held until m_rsp_ready.
  - On valid & ready: m_rsp_valid goes to 0 and state returns to IDLE next cycle.
- wbm_ack_i outside BUS is ignored; no state change, no response.
- Ordering: exactly one outstanding transaction; responses are returned in request order.
- Minimum cost per transaction: 1 accept cycle + ack latency + 1 response cycle.
- Back-to-back rule: with m_rsp_ready held high and a 1-cycle ack, the next request is accepted 3 cycles after the previous one.
- Reset mid-BUS or mid-RESP: the Wishbone cycle is abandoned immediately and the pending response is discarded. No response is generated for it after reset release.
- s_req_* inputs are sampled only at the accept edge; later changes are ignored.

Decomposition:
- Shared package: state encoding constants (IDLE, BUS, RESP) and the default TIMEOUT constant, reused by the other Wishbone masters in the library.
- No sub-module: the timer, FSM and output registers sit in one module of about 150–200 lines of RTL.

Test Plan:
- Write: request addr=3, data=0x5A, we=1 with ack 1 cycle after stb → one cycle with adr=3, dat_o=0x5A, we=1; response data=0x00, err=0; cyc low the cycle after ack.
- Read: request addr=4, we=0; slave returns 0xC3 with ack 2 cycles after stb → response data=0xC3, err=0, m_rsp_valid rises the cycle after ack.
- Timeout: TIMEOUT=8, slave never acks → cyc/stb high for exactly 8 cycles, then response err=1, data=0x00; ack arriving later is ignored.
- Backpressure: m_rsp_ready low for 5 cycles after the response → valid, data and err held stable; s_req_ready stays 0 until the handshake; next request accepted after it.
- Ack on final timeout cycle: TIMEOUT=4, ack at timer=3 → err=0 with captured read data.
- Reset during BUS: assert rst 2 cycles into a read → cyc, stb and busy go 0 asynchronously; after release no response appears and the next request completes normally.
